// File: rtl/wbf_pkg.sv
// Shared Weight Buffer definitions: config opcodes, FSM states and the
// default datapath widths used by both the WBF and the WCA.
package wbf_pkg;

  localparam int unsigned WBF_DATA_WIDTH = 8;
  localparam int unsigned WBF_ADDR_WIDTH = 8;
  localparam int unsigned WBF_ISA_WIDTH  = 2;

  localparam logic [1:0] ISA_NOP   = 2'b00;
  localparam logic [1:0] ISA_LOAD  = 2'b01;
  localparam logic [1:0] ISA_SERVE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_e;

endpackage

// File: rtl/wbf_mem.sv
// Single-port weight array: synchronous write, synchronous registered read.
// Behavioural SRAM model that a memory macro can replace.
module wbf_mem
  import wbf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WBF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WBF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/wbf_responder.sv
// Weight Buffer responder: fills the weight array from GLB and serves WCA
// reads with one cycle of latency and full back-pressure.
module wbf_responder
  import wbf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = WBF_DATA_WIDTH,
  parameter int unsigned WEI_ADDR_WIDTH = WBF_ADDR_WIDTH,
  parameter int unsigned ISA_WIDTH      = WBF_ISA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      TOPWBF_CfgVld,
  input  logic [ISA_WIDTH-1:0]      TOPWBF_CfgISA,
  input  logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgNum,
  output logic                      WBFTOP_CfgRdy,
  input  logic                      GLBWBF_DatVld,
  input  logic [DATA_WIDTH-1:0]     GLBWBF_Dat,
  output logic                      WBFGLB_DatRdy,
  input  logic                      WCAWBF_AdrVld,
  input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
  output logic                      WBFWCA_AdrRdy,
  output logic                      WBFWCA_DatVld,
  output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
  input  logic                      WCAWBF_DatRdy
);

  localparam int unsigned    CW    = WEI_ADDR_WIDTH + 1;
  localparam logic [CW-1:0]  DEPTH = CW'(1) << WEI_ADDR_WIDTH;

  state_e                    state_q;
  logic [CW-1:0]             num_q, num_d;
  logic [CW-1:0]             wr_cnt_q, acc_cnt_q, dlv_cnt_q, loaded_q;
  logic                      dat_vld_q, in_rng_q;
  logic                      cfg_fire, fill_fire, adr_fire, dat_fire;
  logic [WEI_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  assign num_d = (TOPWBF_CfgNum > DEPTH) ? DEPTH : TOPWBF_CfgNum;

  assign WBFTOP_CfgRdy = (state_q == IDLE);
  assign WBFGLB_DatRdy = (state_q == LOAD) && (wr_cnt_q < num_q);
  assign WBFWCA_AdrRdy = (state_q == SERVE) && (acc_cnt_q < num_q) &&
                         (!dat_vld_q || WCAWBF_DatRdy);
  assign WBFWCA_DatVld = dat_vld_q;
  // Out-of-range reads and empty slots present zero instead of stale array data.
  assign WBFWCA_Dat    = in_rng_q ? mem_rdata : '0;

  assign cfg_fire  = TOPWBF_CfgVld & WBFTOP_CfgRdy;
  assign fill_fire = GLBWBF_DatVld & WBFGLB_DatRdy;
  assign adr_fire  = WCAWBF_AdrVld & WBFWCA_AdrRdy;
  assign dat_fire  = dat_vld_q & WCAWBF_DatRdy;

  assign mem_addr = (state_q == LOAD) ? wr_cnt_q[WEI_ADDR_WIDTH-1:0] : WCAWBF_Adr;

  wbf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (WEI_ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (fill_fire),
    .re_i    (adr_fire),
    .addr_i  (mem_addr),
    .wdata_i (GLBWBF_Dat),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      wr_cnt_q  <= '0;
      acc_cnt_q <= '0;
      dlv_cnt_q <= '0;
      loaded_q  <= '0;
      dat_vld_q <= 1'b0;
      in_rng_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_fire) begin
            if (TOPWBF_CfgISA == ISA_WIDTH'(ISA_LOAD)) begin
              state_q  <= LOAD;
              num_q    <= num_d;
              wr_cnt_q <= '0;
            end else if (TOPWBF_CfgISA == ISA_WIDTH'(ISA_SERVE)) begin
              state_q   <= SERVE;
              num_q     <= num_d;
              acc_cnt_q <= '0;
              dlv_cnt_q <= '0;
            end
          end
        end
        LOAD: begin
          if (fill_fire) begin
            wr_cnt_q <= wr_cnt_q + CW'(1);
          end else if (wr_cnt_q == num_q) begin
            loaded_q <= num_q;
            state_q  <= IDLE;
          end
        end
        SERVE: begin
          // A new address replaces the beat leaving this cycle, keeping 1 word/cycle.
          if (adr_fire) begin
            dat_vld_q <= 1'b1;
            in_rng_q  <= ({1'b0, WCAWBF_Adr} < loaded_q);
            acc_cnt_q <= acc_cnt_q + CW'(1);
          end else if (dat_fire) begin
            dat_vld_q <= 1'b0;
            in_rng_q  <= 1'b0;
          end
          if (dat_fire) dlv_cnt_q <= dlv_cnt_q + CW'(1);
          if (dlv_cnt_q == num_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbf_responder.sv
// Randomized self-checking bench for wbf_responder against an array-based
// model of the weight buffer contents and the in-order read beats.
module tb_wbf_responder;
  import wbf_pkg::*;

  localparam int DEPTH = 256;

  logic       clk, rst;
  logic       cfg_vld;
  logic [1:0] cfg_isa;
  logic [8:0] cfg_num;
  logic       cfg_rdy;
  logic       fill_vld;
  logic [7:0] fill_dat;
  logic       fill_rdy;
  logic       adr_vld;
  logic [7:0] adr;
  logic       adr_rdy;
  logic       dat_vld;
  logic [7:0] dat;
  logic       dat_rdy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mem_m [DEPTH];
  int         loaded_m = 0;
  logic [7:0] fill_q [$];
  int         addr_q [$];
  logic [7:0] exp_q  [$];

  wbf_responder dut (
    .clk           (clk),
    .rst           (rst),
    .TOPWBF_CfgVld (cfg_vld),
    .TOPWBF_CfgISA (cfg_isa),
    .TOPWBF_CfgNum (cfg_num),
    .WBFTOP_CfgRdy (cfg_rdy),
    .GLBWBF_DatVld (fill_vld),
    .GLBWBF_Dat    (fill_dat),
    .WBFGLB_DatRdy (fill_rdy),
    .WCAWBF_AdrVld (adr_vld),
    .WCAWBF_Adr    (adr),
    .WBFWCA_AdrRdy (adr_rdy),
    .WBFWCA_DatVld (dat_vld),
    .WBFWCA_Dat    (dat),
    .WCAWBF_DatRdy (dat_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_rd(input int a);
    return (a < loaded_m) ? mem_m[a] : 8'h00;
  endfunction

  // Issue one config transfer; returns one cycle after it was accepted.
  task automatic cfg(input logic [1:0] isa, input int num);
    int t = 0;
    @(posedge clk); #1;
    cfg_vld = 1'b1; cfg_isa = isa; cfg_num = 9'(num);
    @(negedge clk);
    while (!cfg_rdy && t < 50) begin @(negedge clk); t++; end
    check("cfg_rdy", 32'(cfg_rdy), 32'(1));
    @(posedge clk); #1;
    cfg_vld = 1'b0;
  endtask

  task automatic load(input int num);
    int  n = (num > DEPTH) ? DEPTH : num;
    int  cnt = 0;
    int  t = 0;
    bit  xfer;
    cfg(ISA_LOAD, num);
    while (cnt < n && t < 5000) begin
      if (!fill_vld && $urandom_range(0, 3) != 0) begin
        fill_vld = 1'b1;
        fill_dat = (fill_q.size() != 0) ? fill_q.pop_front() : 8'($urandom);
      end
      @(negedge clk);
      check("fill_rdy", 32'(fill_rdy), 32'(cnt < n));
      xfer = fill_vld && fill_rdy;
      if (xfer) begin mem_m[cnt] = fill_dat; cnt++; end
      @(posedge clk); #1;
      if (xfer) fill_vld = 1'b0;
      t++;
    end
    check("fill_cnt", 32'(cnt), 32'(n));
    fill_vld = 1'b0;
    t = 0;
    @(negedge clk);
    while (!cfg_rdy && t < 8) begin @(negedge clk); t++; end
    check("load_idle", 32'(cfg_rdy), 32'(1));
    check("load_idle_fill_rdy", 32'(fill_rdy), 32'(0));
    loaded_m = n;
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 stall 5 cycles on the first beat.
  task automatic serve(input int n, input bit rnd_vld, input int rdy_mode);
    int         idx = 0, beats = 0, t = 0, stall = 0;
    bit         prev_stall = 0, exp_vld = 0, xfer_a;
    logic [7:0] prev_dat = 8'h00;
    exp_q.delete();
    cfg(ISA_SERVE, n);
    while (beats < n && t < 4000) begin
      if (!adr_vld && idx < n && (!rnd_vld || $urandom_range(0, 1) == 1)) begin
        adr_vld = 1'b1;
        adr     = 8'(addr_q[idx]);
      end
      case (rdy_mode)
        0:       dat_rdy = 1'b1;
        1:       dat_rdy = 1'($urandom_range(0, 1));
        default: dat_rdy = !(dat_vld && stall < 5);
      endcase
      @(negedge clk);
      if (prev_stall) begin
        check("hold_vld", 32'(dat_vld), 32'(1));
        check("hold_dat", 32'(dat), 32'(prev_dat));
      end
      if (exp_vld) check("latency_vld", 32'(dat_vld), 32'(1));
      if (dat_vld && !dat_rdy) check("stall_adr_rdy", 32'(adr_rdy), 32'(0));
      if (idx >= n) check("adr_rdy_done", 32'(adr_rdy), 32'(0));
      else if (rdy_mode == 0 && !rnd_vld) check("adr_rdy_b2b", 32'(adr_rdy), 32'(1));
      if (dat_vld && dat_rdy) begin
        if (exp_q.size() == 0) check("beat_expected", 32'(exp_q.size()), 32'(1));
        else begin
          check("rd_dat", 32'(dat), 32'(exp_q.pop_front()));
          beats++;
        end
      end
      xfer_a = adr_vld && adr_rdy;
      if (xfer_a) begin
        exp_q.push_back(model_rd(addr_q[idx]));
        idx++;
      end
      exp_vld    = xfer_a;
      if (dat_vld && !dat_rdy) stall++;
      prev_stall = dat_vld && !dat_rdy;
      prev_dat   = dat;
      @(posedge clk); #1;
      if (xfer_a) adr_vld = 1'b0;
      t++;
    end
    check("serve_beats", 32'(beats), 32'(n));
    adr_vld = 1'b0;
    dat_rdy = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cfg_rdy && t < 8) begin @(negedge clk); t++; end
    check("serve_idle", 32'(cfg_rdy), 32'(1));
    check("serve_idle_vld", 32'(dat_vld), 32'(0));
  endtask

  initial begin
    int t;
    rst = 1'b1;
    cfg_vld = 0; cfg_isa = 0; cfg_num = 0;
    fill_vld = 0; fill_dat = 0;
    adr_vld = 0; adr = 0; dat_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_rdy", 32'(cfg_rdy), 32'(1));
    check("rst_fill_rdy", 32'(fill_rdy), 32'(0));
    check("rst_adr_rdy", 32'(adr_rdy), 32'(0));
    check("rst_dat_vld", 32'(dat_vld), 32'(0));
    check("rst_dat", 32'(dat), 32'(0));
    rst = 1'b0;

    // Basic load and shuffled serve, then an out-of-range read.
    fill_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load(4);
    addr_q = '{3, 0, 2, 1};
    serve(4, 0, 0);
    addr_q = '{10};
    serve(1, 0, 0);

    // Back-pressure holding the first beat.
    addr_q = '{0, 1, 2};
    serve(3, 0, 2);

    // Opcodes that do nothing.
    cfg(ISA_NOP, 5);
    @(negedge clk);
    check("nop_cfg_rdy", 32'(cfg_rdy), 32'(1));
    check("nop_adr_rdy", 32'(adr_rdy), 32'(0));
    cfg(2'b11, 7);
    @(negedge clk);
    check("isa11_cfg_rdy", 32'(cfg_rdy), 32'(1));
    check("isa11_fill_rdy", 32'(fill_rdy), 32'(0));

    // Zero-length serve and load.
    cfg(ISA_SERVE, 0);
    @(negedge clk);
    check("zero_serve_busy", 32'(cfg_rdy), 32'(0));
    check("zero_serve_adr_rdy", 32'(adr_rdy), 32'(0));
    @(negedge clk);
    check("zero_serve_idle", 32'(cfg_rdy), 32'(1));
    cfg(ISA_LOAD, 0);
    @(negedge clk);
    check("zero_load_busy", 32'(cfg_rdy), 32'(0));
    check("zero_load_fill_rdy", 32'(fill_rdy), 32'(0));
    @(negedge clk);
    check("zero_load_idle", 32'(cfg_rdy), 32'(1));
    loaded_m = 0;
    addr_q = '{0};
    serve(1, 0, 0);

    // Random handshakes over a partial load.
    load(128);
    addr_q.delete();
    for (int i = 0; i < 64; i++) addr_q.push_back(int'($urandom_range(0, 159)));
    serve(64, 1, 1);

    // Full-depth load read back in order.
    load(256);
    addr_q.delete();
    for (int i = 0; i < 256; i++) addr_q.push_back(i);
    serve(256, 0, 0);

    // Oversized count clamps to the array depth.
    load(300);
    addr_q.delete();
    for (int i = 0; i < 8; i++) addr_q.push_back(int'($urandom_range(0, 255)));
    serve(8, 1, 1);

    // Reset while a beat is stalled on the read side.
    addr_q = '{0, 1};
    cfg(ISA_SERVE, 2);
    adr_vld = 1'b1; adr = 8'd0; dat_rdy = 1'b0;
    t = 0;
    @(negedge clk);
    while (!dat_vld && t < 10) begin @(negedge clk); t++; end
    check("rst_mid_pre_vld", 32'(dat_vld), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_dat_vld", 32'(dat_vld), 32'(0));
    check("rst_mid_dat", 32'(dat), 32'(0));
    check("rst_mid_adr_rdy", 32'(adr_rdy), 32'(0));
    check("rst_mid_fill_rdy", 32'(fill_rdy), 32'(0));
    check("rst_mid_cfg_rdy", 32'(cfg_rdy), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0; adr_vld = 1'b0; dat_rdy = 1'b1;
    loaded_m = 0;
    addr_q = '{0, 1, 2, 200};
    serve(4, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
